// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO sizing defaults for the memory and both pointer/flag controllers.
package fifo_rd_ctrl_pkg;

  localparam int unsigned AddrWidthDef     = 4;
  localparam int unsigned DataWidthDef     = 8;
  localparam int unsigned DepthDef         = 1 << AddrWidthDef;
  localparam int unsigned AlmostEmptyThDef = 2;

endpackage

// File: rtl/fifo_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module fifo_sync2 #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller of the async FIFO; flags come from the
// next-state read pointer so the last-entry read raises rd_empty on the same edge.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth     = AddrWidthDef,
  parameter int unsigned AlmostEmptyTh = AlmostEmptyThDef
) (
  input  logic                 rd_clk_i,
  input  logic                 rd_rst_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth:0]   wr_ptr_gray_i,
  output logic [AddrWidth-1:0] rd_addr_o,
  output logic [AddrWidth:0]   rd_ptr_gray_o,
  output logic                 rd_empty_o,
  output logic                 rd_almost_empty_o,
  output logic [AddrWidth:0]   rd_count_o,
  output logic                 rd_valid_o
);

  localparam int unsigned PtrW = AddrWidth + 1;
  localparam logic [PtrW-1:0] AeTh = PtrW'(AlmostEmptyTh);

  function automatic logic [PtrW-1:0] bin2gray(input logic [PtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
    logic [PtrW-1:0] b;
    b[PtrW-1] = g[PtrW-1];
    for (int i = PtrW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PtrW-1:0] rd_bin_q, rd_bin_d;
  logic [PtrW-1:0] rd_gray_q, rd_gray_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            empty_q, empty_d;
  logic            aempty_q, aempty_d;
  logic            valid_q;
  logic [PtrW-1:0] wq2_gray;
  logic [PtrW-1:0] wq2_bin;
  logic            rd_fire;

  fifo_sync2 #(
    .Width(PtrW)
  ) u_wptr_sync (
    .clk_i(rd_clk_i),
    .rst_i(rd_rst_i),
    .d_i  (wr_ptr_gray_i),
    .q_o  (wq2_gray)
  );

  // Same gating the memory applies, so a read while empty has no side effects.
  assign rd_fire = rd_en_i && !empty_q;

  always_comb begin
    rd_bin_d  = rd_bin_q + PtrW'(rd_fire);
    rd_gray_d = bin2gray(rd_bin_d);
    wq2_bin   = gray2bin(wq2_gray);
    count_d   = wq2_bin - rd_bin_d;
    empty_d   = (rd_gray_d == wq2_gray);
    aempty_d  = (count_d <= AeTh);
  end

  always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
    if (rd_rst_i) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      valid_q   <= rd_fire;
    end
  end

  assign rd_addr_o         = rd_bin_q[AddrWidth-1:0];
  assign rd_ptr_gray_o     = rd_gray_q;
  assign rd_empty_o        = empty_q;
  assign rd_almost_empty_o = aempty_q;
  assign rd_count_o        = count_q;
  assign rd_valid_o        = valid_q;

endmodule
